// File: rtl/ga_pkg.sv
// Shared GA definitions: selection FSM states, LFSR constants and the
// population/index/energy widths common to the evaluator and the selector.
package ga_pkg;

    localparam int GA_POP_SIZE  = 50;
    localparam int GA_IDX_WIDTH = 8;
    localparam int GA_FIT_WIDTH = 10;

    localparam int LFSR_WIDTH = 16;
    // x^16+x^14+x^13+x^11+1 in right-shift form: feedback from bits 0,2,3,5
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'h002D;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAW_A  = 2'd1,
        DRAW_B  = 2'd2,
        OUT     = 2'd3
    } sel_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with seed load; a zero seed falls back to the
// default seed so the register can never lock up at all-zeros.
module lfsr16
    import ga_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  step_i,
    input  logic                  load_i,
    input  logic [LFSR_WIDTH-1:0] seed_i,
    output logic [LFSR_WIDTH-1:0] value_o
);

    logic [LFSR_WIDTH-1:0] value_reg, value_next;
    logic                  feedback;

    always_comb begin
        feedback   = ^(value_reg & LFSR_TAPS);
        value_next = value_reg;
        if (load_i)
            value_next = (seed_i == '0) ? LFSR_SEED : seed_i;
        else if (step_i)
            value_next = {feedback, value_reg[LFSR_WIDTH-1:1]};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n)
            value_reg <= LFSR_SEED;
        else
            value_reg <= value_next;
    end

    assign value_o = value_reg;

endmodule

// File: rtl/tournament_select.sv
// Binary tournament parent selector: collects one fitness per individual, then
// emits POP_SIZE parents chosen by LFSR-driven tournaments (ELITISM_EN: first is best).
module tournament_select
    import ga_pkg::*;
#(
    parameter int POP_SIZE        = GA_POP_SIZE,
    parameter int IDX_WIDTH       = GA_IDX_WIDTH,
    parameter int SELF_FIT_LENGTH = GA_FIT_WIDTH
)(
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       fit_valid_i,
    input  logic [IDX_WIDTH-1:0]       fit_idx_i,
    input  logic [SELF_FIT_LENGTH-1:0] fit_energy_i,
    input  logic                       seed_load_i,
    input  logic [LFSR_WIDTH-1:0]      seed_i,
    input  logic                       sel_ready_i,
    output logic                       parent_valid_o,
    output logic [IDX_WIDTH-1:0]       parent_idx_o,
    output logic [SELF_FIT_LENGTH-1:0] parent_energy_o,
    output logic [IDX_WIDTH-1:0]       best_idx_o,
    output logic [SELF_FIT_LENGTH-1:0] best_energy_o,
    output logic                       busy_o,
    output logic                       gen_done_o,
    output logic                       err_o
);

    localparam int CNT_W  = $clog2(POP_SIZE + 1);
    localparam int ADDR_W = $clog2(POP_SIZE);

    sel_state_t                 state_reg, state_next;
    logic [CNT_W-1:0]           wr_cnt_reg, wr_cnt_next, par_cnt_reg, par_cnt_next;
    logic [IDX_WIDTH-1:0]       best_idx_reg, best_idx_next, cand_a_idx_reg, cand_a_idx_next;
    logic [IDX_WIDTH-1:0]       parent_idx_reg, parent_idx_next;
    logic [SELF_FIT_LENGTH-1:0] best_energy_reg, best_energy_next, cand_a_energy_reg, cand_a_energy_next;
    logic [SELF_FIT_LENGTH-1:0] parent_energy_reg, parent_energy_next;
    logic                       best_valid_reg, best_valid_next;
    logic                       gen_done_reg, gen_done_next, err_reg, err_next;

    logic [SELF_FIT_LENGTH-1:0] fit_mem [POP_SIZE];
    logic                       fit_wr_en, fit_in_range, draw_ok;
    logic [ADDR_W-1:0]          rd_addr;
    logic [IDX_WIDTH-1:0]       draw_idx;
    logic [SELF_FIT_LENGTH-1:0] draw_energy;
    logic [LFSR_WIDTH-1:0]      lfsr_value;
    logic                       lfsr_step, lfsr_load;
    logic                       unused_lfsr_bits;

    lfsr16 u_lfsr (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .step_i  (lfsr_step),
        .load_i  (lfsr_load),
        .seed_i  (seed_i),
        .value_o (lfsr_value)
    );

    assign draw_idx         = lfsr_value[IDX_WIDTH-1:0];
    assign unused_lfsr_bits = ^lfsr_value[LFSR_WIDTH-1:IDX_WIDTH];
    assign draw_ok          = draw_idx < IDX_WIDTH'(POP_SIZE);
    assign fit_in_range     = fit_idx_i < IDX_WIDTH'(POP_SIZE);
    // out-of-range draws are rejected anyway; steer them to a legal address
    assign rd_addr          = draw_ok ? draw_idx[ADDR_W-1:0] : '0;
    assign draw_energy      = fit_mem[rd_addr];

    always_ff @(posedge clk_i) begin
        if (fit_wr_en)
            fit_mem[fit_idx_i[ADDR_W-1:0]] <= fit_energy_i;
    end

    always_comb begin
        state_next         = state_reg;
        wr_cnt_next        = wr_cnt_reg;
        par_cnt_next       = par_cnt_reg;
        best_idx_next      = best_idx_reg;
        best_energy_next   = best_energy_reg;
        best_valid_next    = best_valid_reg;
        cand_a_idx_next    = cand_a_idx_reg;
        cand_a_energy_next = cand_a_energy_reg;
        parent_idx_next    = parent_idx_reg;
        parent_energy_next = parent_energy_reg;
        gen_done_next      = 1'b0;
        err_next           = err_reg;
        fit_wr_en          = 1'b0;
        lfsr_step          = 1'b0;
        lfsr_load          = 1'b0;

        if (fit_valid_i && state_reg != COLLECT)
            err_next = 1'b1;

        case (state_reg)
            COLLECT: begin
                lfsr_load = seed_load_i;
                if (fit_valid_i && !fit_in_range) begin
                    err_next = 1'b1;
                end else if (fit_valid_i) begin
                    fit_wr_en = 1'b1;
                    // strict less-than keeps the earlier write on ties
                    if (!best_valid_reg || fit_energy_i < best_energy_reg) begin
                        best_idx_next    = fit_idx_i;
                        best_energy_next = fit_energy_i;
                        best_valid_next  = 1'b1;
                    end
                    if (wr_cnt_reg == CNT_W'(POP_SIZE - 1)) begin
                        wr_cnt_next = '0;
`ifdef ELITISM_EN
                        parent_idx_next    = best_idx_next;
                        parent_energy_next = best_energy_next;
                        state_next         = OUT;
`else
                        state_next = DRAW_A;
`endif
                    end else begin
                        wr_cnt_next = wr_cnt_reg + 1'b1;
                    end
                end
            end
            DRAW_A: begin
                lfsr_step = 1'b1;
                if (draw_ok) begin
                    cand_a_idx_next    = draw_idx;
                    cand_a_energy_next = draw_energy;
                    state_next         = DRAW_B;
                end
            end
            DRAW_B: begin
                lfsr_step = 1'b1;
                if (draw_ok) begin
                    if (draw_energy < cand_a_energy_reg) begin
                        parent_idx_next    = draw_idx;
                        parent_energy_next = draw_energy;
                    end else begin
                        parent_idx_next    = cand_a_idx_reg;
                        parent_energy_next = cand_a_energy_reg;
                    end
                    state_next = OUT;
                end
            end
            OUT: begin
                if (sel_ready_i) begin
                    if (par_cnt_reg == CNT_W'(POP_SIZE - 1)) begin
                        par_cnt_next    = '0;
                        gen_done_next   = 1'b1;
                        best_valid_next = 1'b0;
                        state_next      = COLLECT;
                    end else begin
                        par_cnt_next = par_cnt_reg + 1'b1;
                        state_next   = DRAW_A;
                    end
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n)
            state_reg <= COLLECT;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wr_cnt_reg        <= '0;
            par_cnt_reg       <= '0;
            best_idx_reg      <= '0;
            best_energy_reg   <= '0;
            best_valid_reg    <= 1'b0;
            cand_a_idx_reg    <= '0;
            cand_a_energy_reg <= '0;
            parent_idx_reg    <= '0;
            parent_energy_reg <= '0;
            gen_done_reg      <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            wr_cnt_reg        <= wr_cnt_next;
            par_cnt_reg       <= par_cnt_next;
            best_idx_reg      <= best_idx_next;
            best_energy_reg   <= best_energy_next;
            best_valid_reg    <= best_valid_next;
            cand_a_idx_reg    <= cand_a_idx_next;
            cand_a_energy_reg <= cand_a_energy_next;
            parent_idx_reg    <= parent_idx_next;
            parent_energy_reg <= parent_energy_next;
            gen_done_reg      <= gen_done_next;
            err_reg           <= err_next;
        end
    end

    assign parent_valid_o  = (state_reg == OUT);
    assign parent_idx_o    = parent_idx_reg;
    assign parent_energy_o = parent_energy_reg;
    assign best_idx_o      = best_idx_reg;
    assign best_energy_o   = best_energy_reg;
    assign busy_o          = (state_reg != COLLECT);
    assign gen_done_o      = gen_done_reg;
    assign err_o           = err_reg;

endmodule

// File: tb/tb_tournament_select.sv
// Self-checking bench for tournament_select (POP_SIZE=4); the reference model
// draws parents from an abstract LFSR sequence. Honours ELITISM_EN if defined.
module tb_tournament_select;

    localparam int POP = 4;
`ifdef ELITISM_EN
    localparam bit ELITE = 1'b1;
`else
    localparam bit ELITE = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        fit_valid_i;
    logic [7:0]  fit_idx_i;
    logic [9:0]  fit_energy_i;
    logic        seed_load_i;
    logic [15:0] seed_i;
    logic        sel_ready_i;
    logic        parent_valid_o;
    logic [7:0]  parent_idx_o;
    logic [9:0]  parent_energy_o;
    logic [7:0]  best_idx_o;
    logic [9:0]  best_energy_o;
    logic        busy_o;
    logic        gen_done_o;
    logic        err_o;

    tournament_select #(.POP_SIZE(POP), .IDX_WIDTH(8), .SELF_FIT_LENGTH(10)) dut (
        .clk_i           (clk_i),
        .rst_n           (rst_n),
        .fit_valid_i     (fit_valid_i),
        .fit_idx_i       (fit_idx_i),
        .fit_energy_i    (fit_energy_i),
        .seed_load_i     (seed_load_i),
        .seed_i          (seed_i),
        .sel_ready_i     (sel_ready_i),
        .parent_valid_o  (parent_valid_o),
        .parent_idx_o    (parent_idx_o),
        .parent_energy_o (parent_energy_o),
        .best_idx_o      (best_idx_o),
        .best_energy_o   (best_energy_o),
        .busy_o          (busy_o),
        .gen_done_o      (gen_done_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_mem [POP];
    logic [15:0] m_lfsr;
    int          m_best_idx, m_best_e;
    bit          m_best_valid;
    int          m_draws;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_bench();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // x^16+x^14+x^13+x^11+1, textbook right-shifting Fibonacci form
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[15:1]};
    endfunction

    task automatic model_draw(output int idx);
        logic [15:0] v;
        idx = -1;
        for (int g = 0; g < 100000 && idx < 0; g++) begin
            v      = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
            m_draws++;
            if (int'(v[7:0]) < POP) idx = int'(v[7:0]);
        end
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_load_i = 1'b1;
        seed_i      = s;
        tick();
        seed_load_i = 1'b0;
        m_lfsr      = (s == 16'h0) ? 16'hACE1 : s;
    endtask

    task automatic write_fit(input int idx, input int e);
        fit_valid_i  = 1'b1;
        fit_idx_i    = idx[7:0];
        fit_energy_i = e[9:0];
        tick();
        fit_valid_i  = 1'b0;
        $display("write idx=%0d energy=%0d err=%0b busy=%0b", idx, e, err_o, busy_o);
        if (idx < POP) begin
            m_mem[idx] = e;
            if (!m_best_valid || e < m_best_e) begin
                m_best_idx   = idx;
                m_best_e     = e;
                m_best_valid = 1'b1;
            end
        end
    endtask

    task automatic wait_parent(output int cnt);
        cnt = 0;
        while (parent_valid_o !== 1'b1 && cnt < 5000) begin
            tick();
            fit_valid_i = 1'b0;
            cnt++;
        end
        if (parent_valid_o !== 1'b1) begin
            check("parent_timeout", {31'd0, parent_valid_o}, 32'd1);
            finish_bench();
        end
    endtask

    task automatic run_gen(input int gen, input int hold_first, input bit random_hold, input bit inject);
        int a, b, exp_idx, cnt, hold;
        for (int p = 0; p < POP; p++) begin
            m_draws = 0;
            if (ELITE && p == 0) begin
                exp_idx = m_best_idx;
            end else begin
                model_draw(a);
                model_draw(b);
                exp_idx = (m_mem[b] < m_mem[a]) ? b : a;
            end
            wait_parent(cnt);
            $display("parent gen=%0d n=%0d idx=%0d energy=%0d draws=%0d", gen, p, parent_idx_o, parent_energy_o, cnt);
            check("parent_latency", cnt, m_draws);
            check("parent_idx", {24'd0, parent_idx_o}, exp_idx);
            check("parent_energy", {22'd0, parent_energy_o}, m_mem[exp_idx]);
            hold = (p == 0) ? hold_first : (random_hold ? int'($urandom_range(0, 3)) : 0);
            for (int k = 0; k < hold; k++) begin
                tick();
                check("hold_valid", {31'd0, parent_valid_o}, 32'd1);
                check("hold_idx", {24'd0, parent_idx_o}, exp_idx);
                check("hold_energy", {22'd0, parent_energy_o}, m_mem[exp_idx]);
            end
            sel_ready_i = 1'b1;
            tick();
            sel_ready_i = 1'b0;
            if (p == POP - 1) begin
                check("gen_done_pulse", {31'd0, gen_done_o}, 32'd1);
                check("busy_after_gen", {31'd0, busy_o}, 32'd0);
                check("valid_after_gen", {31'd0, parent_valid_o}, 32'd0);
                tick();
                check("gen_done_width", {31'd0, gen_done_o}, 32'd0);
                m_best_valid = 1'b0;
            end else begin
                check("valid_after_hs", {31'd0, parent_valid_o}, 32'd0);
                check("gen_done_early", {31'd0, gen_done_o}, 32'd0);
                if (inject && p == 0) begin
                    // stray fitness write while the selector is drawing
                    fit_valid_i  = 1'b1;
                    fit_idx_i    = 8'd0;
                    fit_energy_i = 10'd0;
                end
            end
        end
    endtask

    initial begin
        int order [POP];
        int t, j;

        rst_n        = 1'b0;
        fit_valid_i  = 1'b0;
        fit_idx_i    = '0;
        fit_energy_i = '0;
        seed_load_i  = 1'b0;
        seed_i       = '0;
        sel_ready_i  = 1'b0;
        m_lfsr       = 16'hACE1;
        m_best_valid = 1'b0;
        m_best_idx   = 0;
        m_best_e     = 0;
        for (int i = 0; i < POP; i++) m_mem[i] = 0;

        repeat (2) tick();
        check("rst_parent_valid", {31'd0, parent_valid_o}, 32'd0);
        check("rst_parent_idx", {24'd0, parent_idx_o}, 32'd0);
        check("rst_parent_energy", {22'd0, parent_energy_o}, 32'd0);
        check("rst_best_idx", {24'd0, best_idx_o}, 32'd0);
        check("rst_best_energy", {22'd0, best_energy_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_gen_done", {31'd0, gen_done_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        // generation 1: seed 1, energies {9,3,7,3}, long backpressure on first parent
        load_seed(16'h0001);
        write_fit(0, 9);
        write_fit(1, 3);
        write_fit(2, 7);
        check("busy_before_last", {31'd0, busy_o}, 32'd0);
        write_fit(3, 3);
        check("busy_after_last", {31'd0, busy_o}, 32'd1);
        check("g1_best_idx", {24'd0, best_idx_o}, 32'd1);
        check("g1_best_energy", {22'd0, best_energy_o}, 32'd3);
        check("g1_err", {31'd0, err_o}, 32'd0);
        run_gen(1, 10, 1'b0, 1'b0);

        // generation 2: zero seed, out-of-range write, duplicate index
        load_seed(16'h0000);
        write_fit(60, 5);
        check("oor_err", {31'd0, err_o}, 32'd1);
        check("oor_busy", {31'd0, busy_o}, 32'd0);
        check("oor_best_idx", {24'd0, best_idx_o}, m_best_idx);
        check("oor_best_energy", {22'd0, best_energy_o}, m_best_e);
        write_fit(3, $urandom_range(0, 1023));
        write_fit(3, $urandom_range(0, 1023));
        write_fit(0, $urandom_range(0, 1023));
        check("dup_busy", {31'd0, busy_o}, 32'd0);
        write_fit(2, $urandom_range(0, 1023));
        check("g2_busy", {31'd0, busy_o}, 32'd1);
        check("g2_best_idx", {24'd0, best_idx_o}, m_best_idx);
        check("g2_best_energy", {22'd0, best_energy_o}, m_best_e);
        run_gen(2, 0, 1'b1, 1'b0);
        check("g2_err_sticky", {31'd0, err_o}, 32'd1);

        // generation 3: abandoned by reset while a parent is offered
        for (int i = 0; i < POP; i++) write_fit(i, $urandom_range(0, 1023));
        wait_parent(t);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", {31'd0, parent_valid_o}, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_err", {31'd0, err_o}, 32'd0);
        check("midrst_best_energy", {22'd0, best_energy_o}, 32'd0);
        check("midrst_parent_idx", {24'd0, parent_idx_o}, 32'd0);
        m_lfsr       = 16'hACE1;
        m_best_valid = 1'b0;
        m_best_idx   = 0;
        m_best_e     = 0;

        // generation 4: shuffled writes with small energies (ties likely), stray write in DRAW_A
        for (int i = 0; i < POP; i++) order[i] = i;
        for (int i = POP - 1; i > 0; i--) begin
            j        = int'($urandom_range(0, i));
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < POP; i++) write_fit(order[i], $urandom_range(0, 3));
        check("g4_busy", {31'd0, busy_o}, 32'd1);
        check("g4_best_idx", {24'd0, best_idx_o}, m_best_idx);
        check("g4_best_energy", {22'd0, best_energy_o}, m_best_e);
        check("g4_err_clear", {31'd0, err_o}, 32'd0);
        run_gen(4, 1, 1'b1, 1'b1);
        check("g4_err_draw_write", {31'd0, err_o}, 32'd1);

        finish_bench();
    end

endmodule

// File: doc/tournament_select.md
TOURNAMENT_SELECT -- requirements
Module: tournament_select

Interface
REQ-001 Parameters SHALL be POP_SIZE=50 (population size), IDX_WIDTH=8 (individual index width) and SELF_FIT_LENGTH=10 (energy width).
REQ-002 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 fit_valid_i  in  1  fitness write strobe; driven by the evaluator's out_valid_ff_o.
REQ-005 fit_idx_i  in  IDX_WIDTH  individual index of the write (evaluator ind_wb_idx_ff_o).
REQ-006 fit_energy_i  in  SELF_FIT_LENGTH  total energy of the write (evaluator total_energy_ff_o); lower is fitter.
REQ-007 seed_load_i  in  1  load seed_i into the LFSR (honoured in COLLECT only).
REQ-008 seed_i  in  16  LFSR seed.
REQ-009 sel_ready_i  in  1  downstream accepts the parent.
REQ-010 parent_valid_o  out  1  parent_idx_o/parent_energy_o valid.
REQ-011 parent_idx_o  out  IDX_WIDTH  selected parent index.
REQ-012 parent_energy_o  out  SELF_FIT_LENGTH  selected parent energy.
REQ-013 best_idx_o / best_energy_o  out  IDX_WIDTH / SELF_FIT_LENGTH  fittest individual of the current generation.
REQ-014 busy_o  out  1  high in any selection state.
REQ-015 gen_done_o  out  1  one-cycle pulse after the last parent handshake.
REQ-016 err_o  out  1  sticky protocol-error flag.

Function
REQ-017 FSM states SHALL be COLLECT, DRAW_A, DRAW_B, OUT; COLLECT is the reset state.
REQ-018 In COLLECT, fit_valid_i with fit_idx_i<POP_SIZE SHALL write fit_energy_i to entry fit_idx_i and increment the write counter; duplicate indices overwrite and still count.
REQ-019 In COLLECT, fit_idx_i>=POP_SIZE SHALL be dropped and SHALL set err_o.
REQ-020 Best tracking SHALL use a strict less-than against best_energy_o, so on ties the earlier write is kept; the first write of a generation always loads best.
REQ-021 The cycle the counter reaches POP_SIZE, the FSM SHALL go to DRAW_A and the counter SHALL clear.
REQ-022 In any non-COLLECT state, fit_valid_i SHALL be ignored and SHALL set err_o.
REQ-023 LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, reset value 16'hACE1; a zero seed_i SHALL load 16'hACE1.
REQ-024 The LFSR SHALL step once per cycle in DRAW_A/DRAW_B only; a draw is accepted when its low IDX_WIDTH bits are <POP_SIZE, otherwise the state repeats (rejection sampling).
REQ-025 The accepted DRAW_A index is candidate A and the accepted DRAW_B index is candidate B; the winner is the lower energy, with ties going to A; the winner is registered on entering OUT.
REQ-026 In OUT, parent_valid_o SHALL be high with stable data until sel_ready_i is sampled high; the handshake increments the parent counter and the FSM goes to DRAW_A.
REQ-027 Minimum parent-to-parent spacing SHALL be 3 cycles.
REQ-028 After the POP_SIZE-th handshake, gen_done_o SHALL pulse for one cycle, the FSM SHALL return to COLLECT, and best SHALL be invalidated for the next generation.

Reset
REQ-029 With rst_n low at a clock edge: FSM=COLLECT, counters=0, LFSR=16'hACE1, and every output=0, including best_energy_o and err_o.
REQ-030 Reset mid-selection SHALL abandon the generation; stored fitness entries need not be cleared.

Configuration
REQ-031 With ELITISM_EN defined, the first parent of each generation SHALL be best_idx_o/best_energy_o, presented in OUT directly from COLLECT without draws; it counts toward POP_SIZE.
REQ-032 Without ELITISM_EN, all POP_SIZE parents SHALL come from tournaments.

Structure
REQ-033 Package ga_pkg SHALL hold the FSM state enum, LFSR width, polynomial taps and default seed, and the shared width parameters used by the fitness evaluator.
REQ-034 The LFSR SHALL be a sub-module named lfsr16 with ports clk_i, rst_n, step_i, load_i, seed_i, value_o.

Verification
REQ-035 POP_SIZE=4, energies {9,3,7,3} written to idx 0..3 -> best_idx_o=1, best_energy_o=3, FSM leaves COLLECT the cycle after the 4th write.
REQ-036 POP_SIZE=4, sel_ready_i held low 10 cycles in OUT -> parent_valid_o stays high with constant data; exactly 4 handshakes, then gen_done_o high for 1 cycle.
REQ-037 Reference model of the LFSR with seed 16'h0001 -> every parent_idx_o/energy matches the model, including rejected draws and tie-to-A.
REQ-038 fit_idx_i=60 in COLLECT, then fit_valid_i during DRAW_A -> err_o rises and stays set, stored data unchanged.
REQ-039 rst_n low in OUT -> next cycle parent_valid_o=0, FSM=COLLECT; a subsequent 4 writes restart normally.
REQ-040 ELITISM_EN, energies {5,2,8,6} -> first parent is idx 1/energy 2, appearing in the cycle after the 4th write.
